// File: rtl/conv_bf16tomxi_stream_if.sv
// Handshaked stream bundle for conv_bf16tomxi_stream.
// Carries the bf16 input beats (i_valid/o_ready/i_bf16_vec) and the
// quantised MX output block (o_valid/i_ready/o_mx_vec/o_mx_exp).
// Signal names are as seen from the converter: i_* flow into it, o_* out of it.
interface conv_bf16tomxi_stream_if #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
);

  // Input beat: lane 0 carries the lowest block index of the beat
  logic                            i_valid;
  logic                            o_ready;
  logic [lanes-1:0][15:0]          i_bf16_vec;

  // Output block: each element is a signed s1.(bit_width-2) value
  logic                            o_valid;
  logic                            i_ready;
  logic [k-1:0][bit_width-1:0]     o_mx_vec;
  logic [7:0]                      o_mx_exp;

  // Converter side
  modport slave (
    input  i_valid,
    input  i_bf16_vec,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_mx_vec,
    output o_mx_exp
  );

  // Producer/consumer side (drives beats, accepts blocks)
  modport master (
    output i_valid,
    output i_bf16_vec,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_mx_vec,
    input  o_mx_exp
  );

endinterface

// File: rtl/conv_bf16tomxi_stream.sv
// Streaming bf16 -> MXINT block converter.
// Collects k bf16 elements over k/lanes handshaked beats, tracks the running
// max exponent and NaN flag while filling, then quantises the whole block
// against the shared exponent into a registered, backpressured output.
// Optional build macro CONV_BF16TOMXI_RNE_EN: round-to-nearest-even with
// magnitude saturation instead of truncation (exponent path unchanged).
module conv_bf16tomxi_stream #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  conv_bf16tomxi_stream_if.slave bus
);

  localparam int            NBEATS    = k / lanes;
  localparam int            BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [8:0]    SH_BIAS   = 9'(9 - bit_width);
  localparam logic [8:0]    MAX_MAG   = 9'((1 << (bit_width - 1)) - 1);

  typedef enum logic {
    S_FILL,
    S_FULL
  } state_t;

  state_t                           state_q, state_d;
  logic [BW-1:0]                    beat_q, beat_d;
  logic [7:0]                       run_max_q, run_max_d;
  logic                             run_nan_q, run_nan_d;
  logic [NBEATS-1:0][lanes-1:0][15:0] buf_q;

  logic                             o_valid_q, o_valid_d;
  logic [7:0]                       mx_exp_q, mx_exp_d;
  logic [k-1:0][bit_width-1:0]      mx_vec_q, mx_vec_d;

  logic                             buf_full;
  logic                             ready;
  logic                             accept;
  logic                             last_beat;
  logic                             load;
  logic [7:0]                       beat_max;
  logic                             beat_nan;
  logic [k-1:0][15:0]               blk;
  logic [7:0]                       scale;
  logic [k-1:0][bit_width-1:0]      conv;

  // Quantise one bf16 element against the shared exponent s.
  // s >= exp of every element in the block, so sh never goes negative.
  function automatic logic [bit_width-1:0] quant(input logic [15:0] x,
                                                 input logic [7:0]  s);
    logic [7:0] ex;
    logic [7:0] m8;
    logic [8:0] e_eff;
    logic [8:0] s_eff;
    logic [8:0] sh;
    logic [8:0] mag;
`ifdef CONV_BF16TOMXI_RNE_EN
    logic [15:0] ext;
    logic        rnd;
    logic        stk;
`endif
    ex    = x[14:7];
    m8    = {ex != 8'd0, x[6:0]};
    e_eff = (ex == 8'd0) ? 9'd1 : {1'b0, ex};
    s_eff = (s == 8'd0) ? 9'd1 : {1'b0, s};
    sh    = s_eff - e_eff + SH_BIAS;
`ifdef CONV_BF16TOMXI_RNE_EN
    // Beyond a shift of 8 the value is below half an LSB and rounds to 0.
    // Shifting m8 into a 16-bit window keeps every discarded bit for the
    // round/sticky decision.
    if (sh > 9'd8) begin
      mag = '0;
    end else begin
      ext = {m8, 8'h00} >> sh;
      rnd = ext[7];
      stk = |ext[6:0];
      mag = {1'b0, ext[15:8]} + 9'(rnd & (stk | ext[8]));
      if (mag > MAX_MAG) mag = MAX_MAG;
    end
`else
    mag = (sh >= 9'd8) ? 9'd0 : {1'b0, m8 >> sh};
`endif
    return x[15] ? -mag[bit_width-1:0] : mag[bit_width-1:0];
  endfunction

  // Handshake qualifiers; o_ready is held low while reset is asserted
  assign buf_full  = (state_q == S_FULL);
  assign load      = buf_full & (!o_valid_q | bus.i_ready);
  assign ready     = i_rst_n & (!buf_full | !o_valid_q | bus.i_ready);
  assign accept    = bus.i_valid & ready;
  assign last_beat = (beat_q == LAST_BEAT);

  // Per-beat max exponent and NaN detection across the incoming lanes
  always_comb begin
    beat_max = '0;
    beat_nan = 1'b0;
    for (int unsigned l = 0; l < lanes; l++) begin
      if (bus.i_bf16_vec[l][14:7] > beat_max) beat_max = bus.i_bf16_vec[l][14:7];
      beat_nan = beat_nan | (bus.i_bf16_vec[l][14:7] == 8'hFF);
    end
  end

  // Beat counter, running block statistics and FILL/FULL next state
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    run_max_d = run_max_q;
    run_nan_d = run_nan_q;
    if (accept) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      // Beat 0 starts a new block, so stale statistics are overwritten
      if (beat_q == '0) begin
        run_max_d = beat_max;
        run_nan_d = beat_nan;
      end else begin
        run_max_d = (beat_max > run_max_q) ? beat_max : run_max_q;
        run_nan_d = run_nan_q | beat_nan;
      end
    end
    case (state_q)
      S_FILL: if (accept && last_beat) state_d = S_FULL;
      // A last beat landing in the load cycle refills the buffer at once
      S_FULL: if (load) state_d = (accept && last_beat) ? S_FULL : S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Block view of the buffer: element j lives at beat j/lanes, lane j%lanes
  assign blk   = buf_q;
  assign scale = run_nan_q ? 8'hFF : run_max_q;

  // Quantise every element of the buffered block against the shared exponent
  always_comb begin
    conv = '0;
    for (int unsigned j = 0; j < k; j++) begin
      conv[j] = run_nan_q ? '0 : quant(blk[j], run_max_q);
    end
  end

  // Output register: load a converted block or retire a handshaked one
  always_comb begin
    o_valid_d = o_valid_q;
    mx_exp_d  = mx_exp_q;
    mx_vec_d  = mx_vec_q;
    if (load) begin
      o_valid_d = 1'b1;
      mx_exp_d  = scale;
      mx_vec_d  = conv;
    end else if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Control state registers; reset discards any partial block
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FILL;
      beat_q    <= '0;
      run_max_q <= '0;
      run_nan_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      run_max_q <= run_max_d;
      run_nan_q <= run_nan_d;
    end
  end

  // Element buffer; each block fully overwrites it, so it needs no reset
  always_ff @(posedge i_clk) begin
    if (accept) buf_q[beat_q] <= bus.i_bf16_vec;
  end

  // Output block registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      mx_exp_q  <= '0;
      mx_vec_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      mx_exp_q  <= mx_exp_d;
      mx_vec_q  <= mx_vec_d;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = o_valid_q;
  assign bus.o_mx_exp = mx_exp_q;
  assign bus.o_mx_vec = mx_vec_q;

endmodule

// File: tb/tb_conv_bf16tomxi_stream.sv
// Directed bench for conv_bf16tomxi_stream (bit_width=8, k=32, lanes=8).
// A table of blocks with hand-computed results, then hand-written
// backpressure and mid-block reset sequences.
module tb_conv_bf16tomxi_stream;

  localparam int BWD = 8;
  localparam int K   = 32;
  localparam int L   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_bf16tomxi_stream_if #(.bit_width(BWD), .k(K), .lanes(L)) bus ();

  conv_bf16tomxi_stream #(.bit_width(BWD), .k(K), .lanes(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string       name;
    logic [15:0] fill;
    int          ia;
    logic [15:0] va;
    int          ib;
    logic [15:0] vb;
    logic [7:0]  x_exp;
    logic [7:0]  x_fill;
    logic [7:0]  x_a;
    logic [7:0]  x_b;
  } vec_t;

  typedef struct {
    logic [7:0]          e;
    logic [K-1:0][7:0]   v;
    int                  cyc;
  } rec_t;

  vec_t tbl [10];
  rec_t got [$];
  rec_t mon_r;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs and i_ready are stable from the negedge to the next posedge,
  // so a handshake seen here completes at the following posedge.
  always @(negedge clk) begin
    if (mon_en && bus.o_valid && bus.i_ready) begin
      mon_r.e   = bus.o_mx_exp;
      mon_r.v   = bus.o_mx_vec;
      mon_r.cyc = cyc;
      got.push_back(mon_r);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [K-1:0][15:0] mk_blk(input vec_t v);
    logic [K-1:0][15:0] b;
    for (int j = 0; j < K; j++)
      b[j] = (j == v.ia) ? v.va : (j == v.ib) ? v.vb : v.fill;
    return b;
  endfunction

  function automatic logic [K-1:0][7:0] mk_exp(input vec_t v);
    logic [K-1:0][7:0] x;
    for (int j = 0; j < K; j++)
      x[j] = (j == v.ia) ? v.x_a : (j == v.ib) ? v.x_b : v.x_fill;
    return x;
  endfunction

  // Drive nb beats of blk; each beat is held until the DUT accepts it
  task automatic send_beats(input logic [K-1:0][15:0] blk, input int nb);
    for (int b = 0; b < nb; b++) begin
      int t;
      t = 0;
      bus.i_valid = 1'b1;
      for (int l = 0; l < L; l++) bus.i_bf16_vec[l] = blk[b*L + l];
      @(negedge clk);
      while (!bus.o_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.o_ready) check("beat_accept_timeout", {31'd0, bus.o_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic check_outputs(input string nm, input vec_t v);
    logic [K-1:0][7:0] x;
    x = mk_exp(v);
    check({nm, ".exp"}, bus.o_mx_exp, v.x_exp);
    for (int j = 0; j < K; j++)
      check($sformatf("%s.e%0d", nm, j), bus.o_mx_vec[j], x[j]);
  endtask

  initial begin
    tbl[0] = '{"ones",      16'h3F80,  0, 16'h3F80, 1, 16'h3F80, 8'd127, 8'd64, 8'd64,  8'd64};
    tbl[1] = '{"neg2",      16'h3F80,  0, 16'hC000, 1, 16'h3F80, 8'd128, 8'd32, 8'hC0,  8'd32};
`ifdef CONV_BF16TOMXI_RNE_EN
    tbl[2] = '{"round_mid", 16'h0000,  5, 16'h3FC3, 0, 16'h4000, 8'd128, 8'd0,  8'd49,  8'd64};
`else
    tbl[2] = '{"round_mid", 16'h0000,  5, 16'h3FC3, 0, 16'h4000, 8'd128, 8'd0,  8'd48,  8'd64};
`endif
    tbl[3] = '{"sat_top",   16'h0000,  0, 16'h3FFF, 1, 16'h0000, 8'd127, 8'd0,  8'd127, 8'd0};
    tbl[4] = '{"nan",       16'h3F80, 19, 16'h7FC0, 0, 16'h3F80, 8'hFF,  8'd0,  8'd0,   8'd0};
    tbl[5] = '{"after_nan", 16'h3F80,  0, 16'h3F80, 1, 16'h3F80, 8'd127, 8'd64, 8'd64,  8'd64};
    tbl[6] = '{"neg_zero",  16'h8000,  0, 16'h3F80, 1, 16'h8000, 8'd127, 8'd0,  8'd64,  8'd0};
    tbl[7] = '{"underflow", 16'h3F80,  0, 16'h3B80, 1, 16'h3E00, 8'd127, 8'd64, 8'd0,   8'd8};
    tbl[8] = '{"denorm",    16'h0000,  0, 16'h0040, 1, 16'h0000, 8'd0,   8'd0,  8'd32,  8'd0};
    tbl[9] = '{"mixed",     16'h3F80,  0, 16'h4040, 1, 16'hBFC0, 8'd128, 8'd32, 8'd96,  8'hD0};

    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_bf16_vec = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_exp",   {24'd0, bus.o_mx_exp}, 32'd0);
    check("rst_vec",   {31'd0, |bus.o_mx_vec}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, bus.o_ready}, 32'd1);

    // Table: one block each, output expected exactly one cycle after last beat
    for (int i = 0; i < 10; i++) begin
      send_beats(mk_blk(tbl[i]), K / L);
      check({tbl[i].name, ".early"}, {31'd0, bus.o_valid}, 32'd0);
      @(posedge clk);
      #1;
      check({tbl[i].name, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
      check_outputs(tbl[i].name, tbl[i]);
      @(posedge clk);
      #1;
      check({tbl[i].name, ".clear"}, {31'd0, bus.o_valid}, 32'd0);
    end

    // Backpressure: three blocks back to back, sink stalled for 10 cycles
    got.delete();
    mon_en      = 1'b1;
    bus.i_ready = 1'b0;
    fork
      begin
        send_beats(mk_blk(tbl[0]), K / L);
        send_beats(mk_blk(tbl[1]), K / L);
        check("bp_ready_drop", {31'd0, bus.o_ready}, 32'd0);
        send_beats(mk_blk(tbl[9]), K / L);
      end
      begin
        repeat (10) @(posedge clk);
        #3;
        check("bp_hold_valid", {31'd0, bus.o_valid}, 32'd1);
        check("bp_hold_exp",   {24'd0, bus.o_mx_exp}, 32'd127);
        check("bp_hold_e0",    {24'd0, bus.o_mx_vec[0]}, 32'd64);
        bus.i_ready = 1'b1;
      end
    join
    for (int t = 0; t < 40 && got.size() < 3; t++) @(posedge clk);
    #1;
    check("bp_count", got.size(), 32'd3);
    if (got.size() >= 3) begin
      logic [K-1:0][7:0] xa, xb, xc;
      xa = mk_exp(tbl[0]);
      xb = mk_exp(tbl[1]);
      xc = mk_exp(tbl[9]);
      check("bp_blk0_exp", {24'd0, got[0].e}, 32'd127);
      check("bp_blk1_exp", {24'd0, got[1].e}, 32'd128);
      check("bp_blk2_exp", {24'd0, got[2].e}, 32'd128);
      for (int j = 0; j < K; j++) begin
        check($sformatf("bp_blk0.e%0d", j), got[0].v[j], xa[j]);
        check($sformatf("bp_blk1.e%0d", j), got[1].v[j], xb[j]);
        check($sformatf("bp_blk2.e%0d", j), got[2].v[j], xc[j]);
      end
      check("bp_gap01", got[1].cyc - got[0].cyc, 32'd1);
      check("bp_gap12", got[2].cyc - got[1].cyc, 32'd4);
    end
    mon_en = 1'b0;

    // Reset after two beats of a large-exponent block, then a clean block
    begin
      vec_t junk;
      junk = '{"junk", 16'h4300, 0, 16'h4300, 1, 16'h4300, 8'd134, 8'd0, 8'd0, 8'd0};
      send_beats(mk_blk(junk), 2);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid_rst_exp",   {24'd0, bus.o_mx_exp}, 32'd0);
    check("mid_rst_vec",   {31'd0, |bus.o_mx_vec}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", {31'd0, bus.o_ready}, 32'd1);
    send_beats(mk_blk(tbl[0]), K / L);
    @(posedge clk);
    #1;
    check("post_rst.valid", {31'd0, bus.o_valid}, 32'd1);
    check_outputs("post_rst", tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
